// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-stage PC sequencing logic.
package fetch_pkg;

  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] BOOT_PC_DEFAULT = 32'hbfc00000;

  // Redirect source kind; a numerically higher kind has higher priority.
  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_BP   = 2'd1,
    KIND_WB   = 2'd2,
    KIND_INT  = 2'd3
  } redir_kind_t;

  // Controller state, decoded from the pending register and squash count.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SQUASH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_redirect_ctrl_prio_sel.sv
// Four-way priority picker across the live redirect requests and the pending entry.
module redirect_prio_sel
  import fetch_pkg::*;
(
  input  logic            int_valid,
  input  logic [PC_W-1:0] int_pc,
  input  logic            wb_valid,
  input  logic [PC_W-1:0] wb_pc,
  input  logic            bp_valid,
  input  logic [PC_W-1:0] bp_pc,
  input  logic            pend_valid,
  input  redir_kind_t     pend_kind,
  input  logic [PC_W-1:0] pend_pc,
  output logic            win_valid,
  output redir_kind_t     win_kind,
  output logic [PC_W-1:0] win_pc,
  output logic            win_is_pend
);

  // Walk kinds from highest to lowest; a live request beats a pending entry of the same kind.
  always_comb begin
    win_valid   = 1'b0;
    win_kind    = KIND_NONE;
    win_pc      = '0;
    win_is_pend = 1'b0;
    if (int_valid) begin
      win_valid = 1'b1;
      win_kind  = KIND_INT;
      win_pc    = int_pc;
    end else if (pend_valid && pend_kind == KIND_INT) begin
      win_valid   = 1'b1;
      win_kind    = KIND_INT;
      win_pc      = pend_pc;
      win_is_pend = 1'b1;
    end else if (wb_valid) begin
      win_valid = 1'b1;
      win_kind  = KIND_WB;
      win_pc    = wb_pc;
    end else if (pend_valid && pend_kind == KIND_WB) begin
      win_valid   = 1'b1;
      win_kind    = KIND_WB;
      win_pc      = pend_pc;
      win_is_pend = 1'b1;
    end else if (bp_valid) begin
      win_valid = 1'b1;
      win_kind  = KIND_BP;
      win_pc    = bp_pc;
    end else if (pend_valid && pend_kind == KIND_BP) begin
      win_valid   = 1'b1;
      win_kind    = KIND_BP;
      win_pc      = pend_pc;
      win_is_pend = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-stage PC sequencing: redirect arbitration, stall latching and wrong-path squash.
module fetch_redirect_ctrl
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] BOOT_PC    = BOOT_PC_DEFAULT,
  parameter int              SQUASH_CYC = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] cur_pc,
  input  logic            stop,
  input  logic            int_req,
  input  logic [PC_W-1:0] int_pc,
  input  logic            wb_valid,
  input  logic [PC_W-1:0] wb_pc,
  input  logic            bp_token,
  input  logic [PC_W-1:0] bp_pc,
  output logic [PC_W-1:0] next_pc,
  output logic            pc_we,
  output logic            redirect,
  output logic            int_ack,
  output logic            if_flush
);

  localparam logic [2:0] SQ_LOAD = 3'(SQUASH_CYC);

  logic            pend_valid;
  redir_kind_t     pend_kind;
  logic [PC_W-1:0] pend_pc;
  logic [2:0]      sq_cnt;
  fetch_state_t    state;

  logic            win_valid;
  redir_kind_t     win_kind;
  logic [PC_W-1:0] win_pc;
  logic            win_is_pend;

  // Decode the controller state from the pending register and the squash count.
  always_comb begin
    state = ST_RUN;
    if (pend_valid) state = ST_HOLD;
    else if (sq_cnt != 3'd0) state = ST_SQUASH;
  end

  redirect_prio_sel u_prio (
    .int_valid  (int_req),
    .int_pc     (int_pc),
    .wb_valid   (wb_valid),
    .wb_pc      (wb_pc),
    .bp_valid   (bp_token),
    .bp_pc      (bp_pc),
    .pend_valid (state == ST_HOLD),
    .pend_kind  (pend_kind),
    .pend_pc    (pend_pc),
    .win_valid  (win_valid),
    .win_kind   (win_kind),
    .win_pc     (win_pc),
    .win_is_pend(win_is_pend)
  );

  // Drive the PC register in the same cycle so the IROM sees the new address immediately.
  always_comb begin
    next_pc  = cur_pc + 32'd4;
    pc_we    = 1'b1;
    redirect = 1'b0;
    int_ack  = 1'b0;
    if (reset) begin
      next_pc = BOOT_PC;
    end else if (stop) begin
      pc_we   = 1'b0;
      next_pc = cur_pc;
    end else if (win_valid) begin
      next_pc  = win_pc;
      redirect = 1'b1;
      int_ack  = (win_kind == KIND_INT);
    end
  end

  // Flush while the squash count runs; reset also kills whatever is leaving IF.
  always_comb begin
    if_flush = reset || (sq_cnt != 3'd0);
  end

  // Latch redirects during stalls and run the squash counter on unstalled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_kind  <= KIND_NONE;
      pend_pc    <= '0;
      sq_cnt     <= 3'd0;
    end else if (stop) begin
      if (win_valid && !win_is_pend) begin
        pend_valid <= 1'b1;
        pend_kind  <= win_kind;
        pend_pc    <= win_pc;
      end
    end else begin
      pend_valid <= 1'b0;
      pend_kind  <= KIND_NONE;
      if (win_valid) sq_cnt <= SQ_LOAD;
      else if (sq_cnt != 3'd0) sq_cnt <= sq_cnt - 3'd1;
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl, built with a two-cycle squash window.
module tb_fetch_redirect_ctrl;
  import fetch_pkg::*;

  typedef struct {
    bit          rst;
    bit          stop;
    logic [31:0] cur;
    bit          ir;
    logic [31:0] ipc;
    bit          wv;
    logic [31:0] wpc;
    bit          bv;
    logic [31:0] bpc;
    logic [31:0] enpc;
    bit          ewe;
    bit          erd;
    bit          eack;
    bit          efl;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] npc;
    bit          we;
    bit          rd;
    bit          ack;
    bit          fl;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cur_pc;
  logic        stop;
  logic        int_req;
  logic [31:0] int_pc;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        bp_token;
  logic [31:0] bp_pc;
  logic [31:0] next_pc;
  logic        pc_we;
  logic        redirect;
  logic        int_ack;
  logic        if_flush;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[$];
  exp_t exp_q[$];

  fetch_redirect_ctrl #(.BOOT_PC(32'hbfc00000), .SQUASH_CYC(2)) dut (
    .clk(clk), .reset(reset), .cur_pc(cur_pc), .stop(stop),
    .int_req(int_req), .int_pc(int_pc), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .bp_token(bp_token), .bp_pc(bp_pc), .next_pc(next_pc), .pc_we(pc_we),
    .redirect(redirect), .int_ack(int_ack), .if_flush(if_flush)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input bit rst, input bit stp, input logic [31:0] cur,
                              input bit ir, input logic [31:0] ipc,
                              input bit wv, input logic [31:0] wpc,
                              input bit bv, input logic [31:0] bpc,
                              input logic [31:0] enpc, input bit ewe, input bit erd,
                              input bit eack, input bit efl);
    vec_t v;
    v.rst = rst; v.stop = stp; v.cur = cur;
    v.ir = ir; v.ipc = ipc; v.wv = wv; v.wpc = wpc; v.bv = bv; v.bpc = bpc;
    v.enpc = enpc; v.ewe = ewe; v.erd = erd; v.eack = eack; v.efl = efl;
    return v;
  endfunction

  // Plain unstalled cycle with no redirect source active.
  function automatic vec_t seq(input logic [31:0] cur, input logic [31:0] enpc, input bit efl);
    return mk(0, 0, cur, 0, 0, 0, 0, 0, 0, enpc, 1, 0, 0, efl);
  endfunction

  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    reset    = v.rst;
    stop     = v.stop;
    cur_pc   = v.cur;
    int_req  = v.ir;
    int_pc   = v.ipc;
    wb_valid = v.wv;
    wb_pc    = v.wpc;
    bp_token = v.bv;
    bp_pc    = v.bpc;
    e.idx = idx; e.npc = v.enpc; e.we = v.ewe; e.rd = v.erd; e.ack = v.eack; e.fl = v.efl;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("[TB] FAIL scoreboard_empty: no expected entry for sampled output");
      return;
    end
    e = exp_q.pop_front();
    if ({next_pc, pc_we, redirect, int_ack, if_flush} !== {e.npc, e.we, e.rd, e.ack, e.fl}) begin
      n_bad++;
      $display("[TB] FAIL vec%0d: got next_pc=%h we=%b rd=%b ack=%b fl=%b, expected next_pc=%h we=%b rd=%b ack=%b fl=%b",
               e.idx, next_pc, pc_we, redirect, int_ack, if_flush, e.npc, e.we, e.rd, e.ack, e.fl);
    end
  endtask

  task automatic runCycle(input vec_t v, input int idx);
    @(posedge clk);
    #1;
    applyStimulus(v, idx);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    reset = 1'b1; stop = 1'b0; cur_pc = '0;
    int_req = 1'b0; int_pc = '0; wb_valid = 1'b0; wb_pc = '0; bp_token = 1'b0; bp_pc = '0;

    // reset and free run
    vecs.push_back(mk(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 32'hbfc00000, 1, 0, 0, 1));
    vecs.push_back(seq(32'hbfc00000, 32'hbfc00004, 0));
    vecs.push_back(seq(32'hbfc00004, 32'hbfc00008, 0));
    vecs.push_back(seq(32'hbfc00008, 32'hbfc0000c, 0));
    // same-cycle conflict: interrupt wins
    vecs.push_back(mk(0, 0, 32'hbfc0000c, 1, 32'h80000180, 1, 32'hbfc00100, 1, 32'hbfc00200,
                      32'h80000180, 1, 1, 1, 0));
    vecs.push_back(seq(32'h80000180, 32'h80000184, 1));
    vecs.push_back(seq(32'h80000184, 32'h80000188, 1));
    vecs.push_back(seq(32'h80000188, 32'h8000018c, 0));
    // stall latching: BP then WB overwrite, BP never issued
    vecs.push_back(mk(0, 1, 32'h8000018c, 0, 0, 0, 0, 1, 32'h00400010, 32'h8000018c, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h8000018c, 0, 0, 1, 32'h00400020, 0, 0, 32'h8000018c, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h8000018c, 0, 0, 0, 0, 0, 0, 32'h8000018c, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h8000018c, 0, 0, 0, 0, 0, 0, 32'h00400020, 1, 1, 0, 0));
    vecs.push_back(seq(32'h00400020, 32'h00400024, 1));
    vecs.push_back(seq(32'h00400024, 32'h00400028, 1));
    // dropped low priority: WB pending, BP arrives and is ignored
    vecs.push_back(mk(0, 1, 32'h00400028, 0, 0, 1, 32'h00400100, 0, 0, 32'h00400028, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h00400028, 0, 0, 0, 0, 1, 32'h00400030, 32'h00400028, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h00400028, 0, 0, 0, 0, 0, 0, 32'h00400100, 1, 1, 0, 0));
    // squash window stretched by a two-cycle stall
    vecs.push_back(mk(0, 1, 32'h00400100, 0, 0, 0, 0, 0, 0, 32'h00400100, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 32'h00400100, 0, 0, 0, 0, 0, 0, 32'h00400100, 0, 0, 0, 1));
    vecs.push_back(seq(32'h00400100, 32'h00400104, 1));
    vecs.push_back(seq(32'h00400104, 32'h00400108, 1));
    vecs.push_back(seq(32'h00400108, 32'h0040010c, 0));
    // PC+4 wrap
    vecs.push_back(seq(32'hfffffffc, 32'h00000000, 0));
    // live WB beats a pending WB
    vecs.push_back(mk(0, 1, 32'h00000000, 0, 0, 1, 32'h00001000, 0, 0, 32'h00000000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h00000000, 0, 0, 1, 32'h00002000, 0, 0, 32'h00002000, 1, 1, 0, 0));
    vecs.push_back(seq(32'h00002000, 32'h00002004, 1));

    for (int i = 0; i < vecs.size(); i++) runCycle(vecs[i], i);

    // reset while holding a pending interrupt discards it
    runCycle(mk(0, 1, 32'h00002004, 1, 32'h80000180, 0, 0, 0, 0, 32'h00002004, 0, 0, 0, 1), 100);
    runCycle(mk(1, 1, 32'h00002004, 0, 0, 0, 0, 0, 0, 32'hbfc00000, 1, 0, 0, 1), 101);
    runCycle(seq(32'hbfc00000, 32'hbfc00004, 0), 102);
    // held interrupt request arbitrated after reset
    runCycle(mk(0, 0, 32'hbfc00004, 1, 32'h80000180, 0, 0, 0, 0, 32'h80000180, 1, 1, 1, 0), 103);
    runCycle(seq(32'h80000180, 32'h80000184, 1), 104);
    // redirect during an active squash restarts the count
    runCycle(mk(0, 0, 32'h80000184, 0, 0, 0, 0, 1, 32'h00003000, 32'h00003000, 1, 1, 0, 1), 105);
    runCycle(seq(32'h00003000, 32'h00003004, 1), 106);
    runCycle(seq(32'h00003004, 32'h00003008, 1), 107);
    runCycle(seq(32'h00003008, 32'h0000300c, 0), 108);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Sequencing controller for the fetch-stage PC register. It arbitrates every PC redirect source each cycle and drives the PC register's next value and write enable. Sources, highest priority first: interrupt, writeback mispredict correction, branch-predictor token, sequential PC+4. It latches redirects that arrive while the pipeline is stalled and squashes the wrong-path instructions still in flight in the instruction ROM after a redirect.

## Interface
- BOOT_PC, 32'hbfc00000, PC driven during reset
- SQUASH_CYC, 1, cycles of if_flush after a committed redirect (1..7)
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  reset is synchronous and active-high
- cur_pc  in  32  current PC register value
- stop  in  1  hazard-unit stall; PC must hold
- int_req  in  1  interrupt request level, held until int_ack
- int_pc  in  32  interrupt handler PC
- wb_valid  in  1  writeback-stage mispredict correction, 1-cycle pulse
- wb_pc  in  32  corrected PC
- bp_token  in  1  branch-predictor taken hint, 1-cycle pulse
- bp_pc  in  32  predicted target
- next_pc  out  32  value for PC register and IROM address
- pc_we  out  1  PC register write enable
- redirect  out  1  next_pc is a non-sequential target this cycle
- int_ack  out  1  interrupt redirect committed this cycle
- if_flush  out  1  kill the instruction currently leaving IF

## Operation
- Kind encoding: NONE=0, BP=1, WB=2, INT=3. Higher value wins.
- Pending register: pend_valid, pend_kind, pend_pc. Cleared by reset.
- Candidate each cycle: the highest kind among the incoming requests and the pending entry. An incoming request beats a pending entry of equal kind.
- stop=0 (commit cycle):
  - pc_we=1.
  - If a candidate exists: next_pc = candidate pc, redirect=1, pending cleared.
  - Otherwise: next_pc = cur_pc+4, redirect=0.
  - int_ack=1 iff the committed kind is INT.
- stop=1 (hold cycle):
  - pc_we=0, next_pc=cur_pc, redirect=0, int_ack=0.
  - An incoming request with kind ≥ pend_kind, or any request when pend_valid=0, overwrites the pending entry.
  - Lower-kind requests are dropped.
- Squash counter: 3 bits. Loaded with SQUASH_CYC on every committed redirect, including one committed during an active squash, which restarts the count.
  - Decrements only when stop=0 and no redirect commits.
  - if_flush = (count != 0).
- PC+4 wraps modulo 2^32 with no carry out.
- FSM, derived from the registered state:
  - RUN: pend_valid=0 and count=0.
  - HOLD: pend_valid=1.
  - SQUASH: count≠0 and pend_valid=0.
  - RUN→HOLD: stop with a request. HOLD→SQUASH: stop drops. SQUASH→RUN: count reaches 0.

## Timing
- next_pc, pc_we, redirect and int_ack are combinational from the inputs plus registered state, so the IROM sees the address in the same cycle.
- pend_* and the count register update at the posedge.
- if_flush is registered. It rises the cycle after the committed redirect and stays high SQUASH_CYC cycles, excluding stalled cycles.
- Reset cycle: next_pc=BOOT_PC, pc_we=1, redirect=0, int_ack=0, if_flush=1.
- The cycle after reset deasserts: if_flush=0, pending empty.
- Reset mid-HOLD or mid-SQUASH discards all state; a held int_req is re-arbitrated after reset.
- int_req still high in the cycle after int_ack is treated as a new request. The source must drop it on ack.

## Structure
- Shared package fetch_pkg holds:
  - the redirect-kind enum (2 bits)
  - the BOOT_PC default
  - the PC width constant (32)
- Sub-module redirect_prio_sel: purely combinational 4-way priority picker. Inputs are three request valid/pc pairs plus the pending entry; outputs are winner valid, kind and pc.
- The top level holds the pending register, the squash counter and the stop gating.

## Test plan
- Reset, then free run, stop=0, cur_pc tracking next_pc:
  - Reset cycle: next_pc=bfc00000, if_flush=1.
  - Then bfc00004, bfc00008, …, with redirect=0 and if_flush=0.
- Same-cycle conflict: int_req with int_pc=80000180, wb_valid with wb_pc=bfc00100, bp_token with bp_pc=bfc00200:
  - next_pc=80000180, int_ack=1 that cycle.
  - if_flush=1 the next cycle.
- Stall latching: stop=1 for 3 cycles. Cycle 1: bp_token with 00400010. Cycle 2: wb_valid with 00400020.
  - pc_we=0 throughout the stall.
  - On stop=0: next_pc=00400020, redirect=1.
  - The BP target is never issued.
- Dropped low priority: wb pending during a stall, then bp_token 00400030 arrives:
  - pend_pc stays at the WB target.
- Squash with stall, SQUASH_CYC=2: redirect, then stop=1 for 2 cycles, then stop=0:
  - if_flush stays high for 2 unstalled cycles (4 total), then drops.
- Wrap: cur_pc=fffffffc, no request:
  - next_pc=00000000.
- Reset asserted while in HOLD with a pending INT:
  - Next cycle pend_valid=0 and next_pc=bfc00000.
